// File: rtl/nice_icb_pkg.sv
// Shared ICB encodings, the response-entry type, and helpers that decode
// command size into byte-lane masks and replicated write data.
package nice_icb_pkg;

  typedef enum logic [1:0] {
    ICB_SIZE_BYTE = 2'b00,
    ICB_SIZE_HALF = 2'b01,
    ICB_SIZE_WORD = 2'b10,
    ICB_SIZE_ILL  = 2'b11
  } icb_size_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } icb_rsp_ent_t;

  function automatic logic icb_size_err(input icb_size_e sz, input logic [1:0] a);
    case (sz)
      ICB_SIZE_BYTE: return 1'b0;
      ICB_SIZE_HALF: return a[0];
      ICB_SIZE_WORD: return (a != 2'b00);
      default:       return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] icb_lane_mask(input icb_size_e sz, input logic [1:0] a);
    case (sz)
      ICB_SIZE_BYTE: return 4'b0001 << a;
      ICB_SIZE_HALF: return a[1] ? 4'b1100 : 4'b0011;
      ICB_SIZE_WORD: return 4'b1111;
      default:       return 4'b0000;
    endcase
  endfunction

  // Replicating the LSB-justified data puts it on every lane the mask may select.
  function automatic logic [31:0] icb_wdata_align(input icb_size_e sz, input logic [31:0] wd);
    case (sz)
      ICB_SIZE_BYTE: return {4{wd[7:0]}};
      ICB_SIZE_HALF: return {2{wd[15:0]}};
      default:       return wd;
    endcase
  endfunction

endpackage

// File: rtl/icb_rsp_fifo.sv
// Synchronous in-order FIFO for response entries; any depth >= 1.
// Only pointers and occupancy are reset, the entry storage is not.
module icb_rsp_fifo #(
  parameter int  DEPTH = 4,
  parameter type ENT_T = logic [32:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  ENT_T push_ent_i,
  input  logic pop_i,
  output ENT_T head_o,
  output logic empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  ENT_T             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && !empty_o;
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push_i) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_ent_i;
  end

endmodule

// File: rtl/nice_icb_mem_rsp.sv
// ICB memory responder: byte-lane writes, latency-configurable in-order responses.
// Define ICB_MEM_STATS_EN to add saturating read/write/error accept counters.
module nice_icb_mem_rsp
  import nice_icb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          RSP_LAT     = 1,
  parameter int          MAX_OUTST   = 4
) (
  input  logic        nice_clk,
  input  logic        nice_rst_n,
  input  logic        nice_icb_cmd_valid,
  output logic        nice_icb_cmd_ready,
  input  logic [31:0] nice_icb_cmd_addr,
  input  logic        nice_icb_cmd_read,
  input  logic [31:0] nice_icb_cmd_wdata,
  input  logic [1:0]  nice_icb_cmd_size,
  output logic        nice_icb_rsp_valid,
  input  logic        nice_icb_rsp_ready,
  output logic [31:0] nice_icb_rsp_rdata,
  output logic        nice_icb_rsp_err
`ifdef ICB_MEM_STATS_EN
  ,
  output logic [15:0] stat_rd_cnt,
  output logic [15:0] stat_wr_cnt,
  output logic [15:0] stat_err_cnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [CNT_W-1:0] inflt_q, inflt_d;
  icb_size_e        size;
  logic [31:0]      off_w;
  logic [IDX_W-1:0] idx;
  logic             acc, ret, acc_err, range_err;
  logic [3:0]       lane_mask;
  logic [31:0]      wdata_al;
  icb_rsp_ent_t     acc_ent;
  logic             fifo_push;
  icb_rsp_ent_t     fifo_ent;
  icb_rsp_ent_t     head;
  logic             fifo_empty;

  // Command decode and handshake
  assign size      = icb_size_e'(nice_icb_cmd_size);
  assign off_w     = (nice_icb_cmd_addr - BASE_ADDR) >> 2;
  assign idx       = off_w[IDX_W-1:0];
  assign range_err = (nice_icb_cmd_addr < BASE_ADDR) || (off_w >= 32'(DEPTH_WORDS));
  assign acc_err   = icb_size_err(size, nice_icb_cmd_addr[1:0]) || range_err;
  assign lane_mask = icb_lane_mask(size, nice_icb_cmd_addr[1:0]);
  assign wdata_al  = icb_wdata_align(size, nice_icb_cmd_wdata);

  assign nice_icb_cmd_ready = (inflt_q < CNT_W'(MAX_OUTST));
  assign acc = nice_icb_cmd_valid && nice_icb_cmd_ready;
  assign ret = nice_icb_rsp_valid && nice_icb_rsp_ready;

  assign acc_ent.err   = acc_err;
  assign acc_ent.rdata = (nice_icb_cmd_read && !acc_err) ? mem_q[idx] : 32'h0;

  assign inflt_d = inflt_q + CNT_W'(acc) - CNT_W'(ret);

  always_ff @(posedge nice_clk) begin
    if (!nice_rst_n) inflt_q <= '0;
    else             inflt_q <= inflt_d;
  end

  // Memory contents survive reset on purpose.
  always_ff @(posedge nice_clk) begin
    if (acc && !nice_icb_cmd_read && !acc_err) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_mask[l]) mem_q[idx][l*8 +: 8] <= wdata_al[l*8 +: 8];
      end
    end
  end

  // Response delay line: the FIFO write itself is the last latency stage
  generate
    if (RSP_LAT == 1) begin : g_lat1
      assign fifo_push = acc;
      assign fifo_ent  = acc_ent;
    end else begin : g_latn
      logic [RSP_LAT-2:0] vld_q;
      icb_rsp_ent_t       ent_q [RSP_LAT-1];

      always_ff @(posedge nice_clk) begin
        if (!nice_rst_n) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= acc;
          for (int i = 1; i < RSP_LAT - 1; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      always_ff @(posedge nice_clk) begin
        ent_q[0] <= acc_ent;
        for (int i = 1; i < RSP_LAT - 1; i++) ent_q[i] <= ent_q[i-1];
      end

      assign fifo_push = vld_q[RSP_LAT-2];
      assign fifo_ent  = ent_q[RSP_LAT-2];
    end
  endgenerate

  // In-order response queue; in-flight limit keeps it from overflowing
  icb_rsp_fifo #(
    .DEPTH (MAX_OUTST),
    .ENT_T (icb_rsp_ent_t)
  ) u_rsp_fifo (
    .clk_i      (nice_clk),
    .rst_ni     (nice_rst_n),
    .push_i     (fifo_push),
    .push_ent_i (fifo_ent),
    .pop_i      (nice_icb_rsp_ready),
    .head_o     (head),
    .empty_o    (fifo_empty)
  );

  assign nice_icb_rsp_valid = !fifo_empty;
  assign nice_icb_rsp_rdata = nice_icb_rsp_valid ? head.rdata : 32'h0;
  assign nice_icb_rsp_err   = nice_icb_rsp_valid ? head.err : 1'b0;

`ifdef ICB_MEM_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge nice_clk) begin
    if (!nice_rst_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (acc) begin
      if (acc_err)                err_cnt_q <= sat_inc(err_cnt_q);
      else if (nice_icb_cmd_read) rd_cnt_q  <= sat_inc(rd_cnt_q);
      else                        wr_cnt_q  <= sat_inc(wr_cnt_q);
    end
  end

  assign stat_rd_cnt  = rd_cnt_q;
  assign stat_wr_cnt  = wr_cnt_q;
  assign stat_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_nice_icb_mem_rsp.sv
// Directed bench for nice_icb_mem_rsp at default parameters (BASE 0, 256 words,
// RSP_LAT 1, MAX_OUTST 4); stats checks only when ICB_MEM_STATS_EN is defined.
module tb_nice_icb_mem_rsp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
`ifdef ICB_MEM_STATS_EN
  logic [15:0] st_rd, st_wr, st_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] rsp_q [$];

  always #5 clk = ~clk;

  nice_icb_mem_rsp dut (
    .nice_clk           (clk),
    .nice_rst_n         (rst_n),
    .nice_icb_cmd_valid (cmd_valid),
    .nice_icb_cmd_ready (cmd_ready),
    .nice_icb_cmd_addr  (cmd_addr),
    .nice_icb_cmd_read  (cmd_read),
    .nice_icb_cmd_wdata (cmd_wdata),
    .nice_icb_cmd_size  (cmd_size),
    .nice_icb_rsp_valid (rsp_valid),
    .nice_icb_rsp_ready (rsp_ready),
    .nice_icb_rsp_rdata (rsp_rdata),
    .nice_icb_rsp_err   (rsp_err)
`ifdef ICB_MEM_STATS_EN
    ,
    .stat_rd_cnt        (st_rd),
    .stat_wr_cnt        (st_wr),
    .stat_err_cnt       (st_err)
`endif
  );

  // Record every retired response as {err, rdata}
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1)
      rsp_q.push_back({rsp_err, rsp_rdata});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one command and returns 1 time unit after the accepting edge.
  task automatic cmd(input logic rd, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    int n = 0;
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_size = sz;
    @(negedge clk);
    while (cmd_ready !== 1'b1) begin
      n++;
      if (n > 200) begin
        $display("FAIL cmd_accept_timeout: addr %h never accepted (cmd_ready=%b)", a, cmd_ready);
        $fatal(1);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  function automatic logic [32:0] pop_rsp();
    if (rsp_q.size() == 0) return 33'bx;
    return rsp_q.pop_front();
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_size = 2'b10; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_write_read();
    logic [32:0] r;
    cmd(1'b0, 32'h8, 32'hDEAD_BEEF, 2'b10);
    idle(2);
    r = pop_rsp();
    n_cmp++; if (r !== 33'h0) begin n_bad++; $display("FAIL wr_rsp: got %h want 0_00000000", r); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL idle_rsp_valid: got %b want 0", rsp_valid); end
    cmd(1'b1, 32'h8, 32'h0, 2'b10);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_latency_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_rdata: got %h want deadbeef", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b want 0", rsp_err); end
    idle(2);
    r = pop_rsp();
    n_cmp++; if (r !== {1'b0, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL rd_rsp_q: got %h want 0_deadbeef", r); end
  endtask

  task automatic test_lanes();
    logic [32:0] r;
    rsp_q.delete();
    cmd(1'b0, 32'h4, 32'h0, 2'b10);
    cmd(1'b0, 32'h6, 32'hFFFF_FFA5, 2'b00);
    cmd(1'b0, 32'h4, 32'hFFFF_1234, 2'b01);
    cmd(1'b1, 32'h4, 32'h0, 2'b10);
    cmd(1'b0, 32'h7, 32'hFFFF_FF7E, 2'b00);
    cmd(1'b1, 32'h4, 32'h0, 2'b10);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      r = pop_rsp();
      n_cmp++; if (r !== 33'h0) begin n_bad++; $display("FAIL lane_wr_rsp%0d: got %h want 0_00000000", i, r); end
    end
    r = pop_rsp();
    n_cmp++; if (r !== {1'b0, 32'h00A5_1234}) begin n_bad++; $display("FAIL lane_rd1: got %h want 0_00a51234", r); end
    r = pop_rsp();
    n_cmp++; if (r !== 33'h0) begin n_bad++; $display("FAIL lane_wr_rsp3: got %h want 0_00000000", r); end
    r = pop_rsp();
    n_cmp++; if (r !== {1'b0, 32'h7EA5_1234}) begin n_bad++; $display("FAIL lane_rd2: got %h want 0_7ea51234", r); end
  endtask

  task automatic test_errors();
    logic [32:0] r;
    logic [32:0] exp [8];
    exp = '{33'h0, {1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0},
            33'h0, {1'b0, 32'hCAFE_F00D}, {1'b0, 32'h0BAD_CAFE}};
    rsp_q.delete();
    cmd(1'b0, 32'h0,   32'hCAFE_F00D, 2'b10);
    cmd(1'b1, 32'h2,   32'h0,         2'b10);
    cmd(1'b0, 32'h0,   32'hFFFF_FFFF, 2'b11);
    cmd(1'b1, 32'h400, 32'h0,         2'b10);
    cmd(1'b0, 32'h1,   32'hFFFF_FFFF, 2'b01);
    cmd(1'b0, 32'h3FC, 32'h0BAD_CAFE, 2'b10);
    cmd(1'b1, 32'h0,   32'h0,         2'b10);
    cmd(1'b1, 32'h3FC, 32'h0,         2'b10);
    idle(3);
    for (int i = 0; i < 8; i++) begin
      r = pop_rsp();
      n_cmp++; if (r !== exp[i]) begin n_bad++; $display("FAIL err_rsp%0d: got %h want %h", i, r, exp[i]); end
    end
  endtask

  task automatic test_back_to_back_outstanding();
    logic [32:0] r;
    for (int i = 0; i < 6; i++) cmd(1'b0, 32'h40 + 32'(4 * i), 32'hA000_0000 | 32'(i), 2'b10);
    idle(3);
    rsp_q.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) cmd(1'b1, 32'h40 + 32'(4 * i), 32'h0, 2'b10);
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL outst_full_ready: got %b want 0", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL outst_rsp_valid: got %b want 1", rsp_valid); end
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h50; cmd_size = 2'b10;
    repeat (3) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL outst_hold_ready: got %b want 0", cmd_ready); end
    n_cmp++; if (rsp_rdata !== 32'hA000_0000) begin n_bad++; $display("FAIL outst_hold_rdata: got %h want a0000000", rsp_rdata); end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    cmd(1'b1, 32'h50, 32'h0, 2'b10);
    cmd(1'b1, 32'h54, 32'h0, 2'b10);
    idle(6);
    n_cmp++; if (rsp_q.size() !== 6) begin n_bad++; $display("FAIL outst_count: got %0d want 6", rsp_q.size()); end
    for (int i = 0; i < 6; i++) begin
      r = pop_rsp();
      n_cmp++; if (r !== {1'b0, 32'hA000_0000 | 32'(i)}) begin n_bad++; $display("FAIL outst_order%0d: got %h want %h", i, r, {1'b0, 32'hA000_0000 | 32'(i)}); end
    end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL outst_ready_back: got %b want 1", cmd_ready); end
  endtask

  task automatic test_reset_midop();
    logic [32:0] r;
    rsp_q.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) cmd(1'b1, 32'h40 + 32'(4 * i), 32'h0, 2'b10);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL midrst_rdata: got %h want 0", rsp_rdata); end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    idle(2);
    n_cmp++; if (rsp_q.size() !== 0) begin n_bad++; $display("FAIL midrst_stale_rsp: got %0d want 0", rsp_q.size()); end
    cmd(1'b1, 32'h8, 32'h0, 2'b10);
    cmd(1'b1, 32'h44, 32'h0, 2'b10);
    idle(3);
    r = pop_rsp();
    n_cmp++; if (r !== {1'b0, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL midrst_persist0: got %h want 0_deadbeef", r); end
    r = pop_rsp();
    n_cmp++; if (r !== {1'b0, 32'hA000_0001}) begin n_bad++; $display("FAIL midrst_persist1: got %h want 0_a0000001", r); end
  endtask

`ifdef ICB_MEM_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    n_cmp++; if (st_rd !== 16'd0) begin n_bad++; $display("FAIL stat_rd_reset: got %0d want 0", st_rd); end
    cmd(1'b1, 32'h8,  32'h0, 2'b10);
    cmd(1'b0, 32'h60, 32'h1, 2'b10);
    cmd(1'b1, 32'h40, 32'h0, 2'b10);
    cmd(1'b1, 32'h2,  32'h0, 2'b10);
    cmd(1'b0, 32'h62, 32'h2, 2'b01);
    cmd(1'b1, 32'h4,  32'h0, 2'b10);
    idle(3);
    n_cmp++; if (st_rd !== 16'd3) begin n_bad++; $display("FAIL stat_rd: got %0d want 3", st_rd); end
    n_cmp++; if (st_wr !== 16'd2) begin n_bad++; $display("FAIL stat_wr: got %0d want 2", st_wr); end
    n_cmp++; if (st_err !== 16'd1) begin n_bad++; $display("FAIL stat_err: got %0d want 1", st_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_lanes();
    test_errors();
    test_back_to_back_outstanding();
    test_reset_midop();
`ifdef ICB_MEM_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
